// File: rtl/usr_pkg.sv
// Shared mode codes and FSM state encoding for the universal shift register.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/usr_step.sv
// Combinational single-step function: next register value for a given mode.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [MODE_W-1:0] mode,
  input  logic              si_lsb,
  input  logic              si_msb,
  input  logic [WIDTH-1:0]  load_data,
  output logic [WIDTH-1:0]  nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHL:  nxt = {cur[WIDTH-2:0], si_lsb};
      MODE_SHR:  nxt = {si_msb, cur[WIDTH-1:1]};
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_LOAD: nxt = load_data;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with single-step operation and a counted
// multi-step command (start/busy/done).
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic              si_lsb,
  input  logic              si_msb,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  input  logic [AMT_W-1:0]  amount,
  output logic [WIDTH-1:0]  out,
  output logic              so_msb,
  output logic              so_lsb,
  output logic              busy,
  output logic              done
);

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  out_reg, out_next;
  logic [AMT_W-1:0]  cnt_reg, cnt_next;
  logic [MODE_W-1:0] cmd_reg, cmd_next;
  logic              done_reg, done_next;
  logic [MODE_W-1:0] step_mode;
  logic [WIDTH-1:0]  step_val;

  // RUN steps with the latched command; IDLE steps with the live mode.
  assign step_mode = (state_reg == ST_RUN) ? cmd_reg : mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .cur       (out_reg),
    .mode      (step_mode),
    .si_lsb    (si_lsb),
    .si_msb    (si_msb),
    .load_data (load_data),
    .nxt       (step_val)
  );

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    cnt_next   = cnt_reg;
    cmd_next   = cmd_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cmd_next = mode;
          cnt_next = amount;
          if (amount == '0 || mode == MODE_LOAD || mode == MODE_HOLD || mode == 3'd7) begin
            // Degenerate command: only LOAD changes the register; shifts with zero count do nothing.
            if (mode == MODE_LOAD) out_next = step_val;
            done_next = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end else if (en) begin
          out_next = step_val;
        end
      end
      ST_RUN: begin
        if (en) begin
          out_next = step_val;
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == AMT_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      out_reg   <= '0;
      cnt_reg   <= '0;
      cmd_reg   <= MODE_HOLD;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
      cmd_reg   <= cmd_next;
      done_reg  <= done_next;
    end
  end

  assign out    = out_reg;
  assign so_msb = out_reg[WIDTH-1];
  assign so_lsb = out_reg[0];
  assign busy   = (state_reg == ST_RUN);
  assign done   = done_reg;

endmodule
